// File: rtl/lane_queue_sensor.sv
// rtl/lane_queue_sensor.sv - per-lane vehicle queue model and light-sequence checker
module lane_queue_sensor #(
    parameter int QDEPTH_W      = 4,
    parameter int DEPART_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            arrive,
    input  logic [3:0]            Red,
    input  logic [3:0]            Green,
    input  logic [3:0]            Yellow,
    output logic [3:0]            Traffic,
    output logic [4*QDEPTH_W-1:0] queue_cnt,
    output logic [3:0]            depart,
    output logic [3:0]            overflow,
    output logic                  conflict
);

    // Saturation value of a lane queue and the pace value on which a vehicle leaves.
    localparam logic [QDEPTH_W-1:0] CNT_MAX   = {QDEPTH_W{1'b1}};
    localparam logic [QDEPTH_W-1:0] CNT_ONE   = QDEPTH_W'(1);
    localparam logic [3:0]          PACE_LAST = 4'(DEPART_CYCLES - 1);

    logic [QDEPTH_W-1:0] cnt  [4];
    logic [3:0]          pace [4];

    logic [3:0] nonempty;
    logic [3:0] pacing;
    logic [3:0] drain;
    logic [3:0] lane_bad;
    logic       green_multi;
    logic       conflict_now;

    // Per-lane drain decision and light legality, all from registered state and current lights.
    always_comb begin
        nonempty = 4'b0000;
        pacing   = 4'b0000;
        drain    = 4'b0000;
        lane_bad = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            nonempty[i] = (cnt[i] != '0);
            // A lane only makes progress while its Green is lit and vehicles are waiting.
            pacing[i]   = Green[i] && nonempty[i];
            drain[i]    = pacing[i] && (pace[i] == PACE_LAST);
            // Exactly one of Red/Green/Yellow must be lit; dark lanes are illegal too.
            case ({Red[i], Green[i], Yellow[i]})
                3'b100, 3'b010, 3'b001: lane_bad[i] = 1'b0;
                default:                lane_bad[i] = 1'b1;
            endcase
        end
        // Clearing the lowest set bit leaves something only if two or more greens are lit.
        green_multi  = ((Green & (Green - 4'd1)) != 4'd0);
        conflict_now = green_multi || (lane_bad != 4'b0000);
    end

    // Requests and the flattened count view come straight from the registered counts.
    always_comb begin
        Traffic   = nonempty;
        queue_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            queue_cnt[i*QDEPTH_W +: QDEPTH_W] = cnt[i];
        end
    end

    // Queue counts, pacing, departure pulses and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]  <= '0;
                pace[i] <= 4'd0;
            end
            depart   <= 4'b0000;
            overflow <= 4'b0000;
            conflict <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Partial progress is dropped whenever Green goes away or the lane empties.
                if (!pacing[i]) begin
                    pace[i] <= 4'd0;
                end else if (drain[i]) begin
                    pace[i] <= 4'd0;
                end else begin
                    pace[i] <= pace[i] + 4'd1;
                end

                // An arrival and a departure on the same edge cancel, even at full.
                if (arrive[i] && !drain[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end else if (drain[i] && !arrive[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end

                depart[i] <= drain[i];
            end

            if (conflict_now) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lane_queue_sensor.sv
// tb/tb_lane_queue_sensor.sv - directed self-checking bench for lane_queue_sensor
module tb_lane_queue_sensor;

    logic        clk;
    logic        rst;
    logic [3:0]  arrive;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Yellow;
    logic [3:0]  Traffic;
    logic [15:0] queue_cnt;
    logic [3:0]  depart;
    logic [3:0]  overflow;
    logic        conflict;

    int checks = 0;
    int errors = 0;

    lane_queue_sensor #(
        .QDEPTH_W      (4),
        .DEPART_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arrive    (arrive),
        .Red       (Red),
        .Green     (Green),
        .Yellow    (Yellow),
        .Traffic   (Traffic),
        .queue_cnt (queue_cnt),
        .depart    (depart),
        .overflow  (overflow),
        .conflict  (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full clock: inputs set after a negedge are sampled by the next posedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic all_red();
        Red    = 4'b1111;
        Green  = 4'b0000;
        Yellow = 4'b0000;
        arrive = 4'b0000;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        arrive = 4'b1111;
        Green  = 4'b1111;
        Red    = 4'b0000;
        Yellow = 4'b0000;
        repeat (3) cyc();
        checks++;
        if (Traffic !== 4'b0000) begin
            errors++; $display("FAIL reset_traffic got %b want 0000", Traffic);
        end
        checks++;
        if (queue_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_queue_cnt got %h want 0000", queue_cnt);
        end
        checks++;
        if ({depart, overflow, conflict} !== 9'd0) begin
            errors++; $display("FAIL reset_flags got %b want 000000000", {depart, overflow, conflict});
        end
        all_red();
        rst = 1'b0;
        #1;
        checks++;
        if ({Traffic, queue_cnt, depart, overflow, conflict} !== 29'd0) begin
            errors++; $display("FAIL release_before_edge got %h want 0", {Traffic, queue_cnt, depart, overflow, conflict});
        end
        cyc();
        checks++;
        if ({Traffic, queue_cnt, depart, overflow, conflict} !== 29'd0) begin
            errors++; $display("FAIL release_after_edge got %h want 0", {Traffic, queue_cnt, depart, overflow, conflict});
        end
    endtask

    task automatic test_arrivals();
        arrive = 4'b1000;
        cyc();
        checks++;
        if (queue_cnt[15:12] !== 4'd1) begin
            errors++; $display("FAIL arrive_latency got %0d want 1", queue_cnt[15:12]);
        end
        cyc();
        cyc();
        arrive = 4'b0000;
        cyc();
        checks++;
        if (queue_cnt !== 16'h3000) begin
            errors++; $display("FAIL arrive_count got %h want 3000", queue_cnt);
        end
        checks++;
        if (Traffic !== 4'b1000) begin
            errors++; $display("FAIL arrive_traffic got %b want 1000", Traffic);
        end
        checks++;
        if ({depart, conflict} !== 5'd0) begin
            errors++; $display("FAIL arrive_quiet got %b want 00000", {depart, conflict});
        end
    endtask

    task automatic test_drain_pacing();
        logic [3:0] exp_dep;
        logic [3:0] exp_cnt;
        Green = 4'b1000;
        Red   = 4'b0111;
        for (int j = 1; j <= 10; j++) begin
            cyc();
            exp_dep = (j == 3 || j == 6 || j == 9) ? 4'b1000 : 4'b0000;
            exp_cnt = (j < 3) ? 4'd3 : (j < 6) ? 4'd2 : (j < 9) ? 4'd1 : 4'd0;
            checks++;
            if (depart !== exp_dep || queue_cnt[15:12] !== exp_cnt) begin
                errors++;
                $display("FAIL drain_step%0d got dep=%b cnt=%0d want dep=%b cnt=%0d",
                         j, depart, queue_cnt[15:12], exp_dep, exp_cnt);
            end
        end
        checks++;
        if (Traffic !== 4'b0000) begin
            errors++; $display("FAIL drain_traffic_drop got %b want 0000", Traffic);
        end
        all_red();
    endtask

    task automatic test_back_to_back();
        arrive = 4'b0100;
        cyc();
        cyc();
        arrive = 4'b0000;
        Green  = 4'b0100;
        Red    = 4'b1011;
        cyc();
        cyc();
        arrive = 4'b0100;
        cyc();
        checks++;
        if (queue_cnt[11:8] !== 4'd2 || depart !== 4'b0100) begin
            errors++; $display("FAIL simul_arrive_drain got cnt=%0d dep=%b want cnt=2 dep=0100", queue_cnt[11:8], depart);
        end
        all_red();
        arrive = 4'b0100;
        repeat (13) cyc();
        arrive = 4'b0000;
        cyc();
        checks++;
        if (queue_cnt[11:8] !== 4'd15 || overflow !== 4'b0000) begin
            errors++; $display("FAIL fill_to_max got cnt=%0d ovf=%b want cnt=15 ovf=0000", queue_cnt[11:8], overflow);
        end
        Green = 4'b0100;
        Red   = 4'b1011;
        cyc();
        cyc();
        arrive = 4'b0100;
        cyc();
        checks++;
        if (queue_cnt[11:8] !== 4'd15 || depart !== 4'b0100 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL full_with_drain got cnt=%0d dep=%b ovf=%b want cnt=15 dep=0100 ovf=0000",
                     queue_cnt[11:8], depart, overflow);
        end
        all_red();
        arrive = 4'b0100;
        cyc();
        arrive = 4'b0000;
        checks++;
        if (queue_cnt[11:8] !== 4'd15 || overflow !== 4'b0100) begin
            errors++; $display("FAIL overflow_set got cnt=%0d ovf=%b want cnt=15 ovf=0100", queue_cnt[11:8], overflow);
        end
        repeat (3) cyc();
        checks++;
        if (overflow !== 4'b0100 || queue_cnt[11:8] !== 4'd15) begin
            errors++; $display("FAIL overflow_sticky got cnt=%0d ovf=%b want cnt=15 ovf=0100", queue_cnt[11:8], overflow);
        end
    endtask

    task automatic test_yellow_interrupt();
        arrive = 4'b0001;
        cyc();
        cyc();
        arrive = 4'b0000;
        Green  = 4'b0001;
        Red    = 4'b1110;
        cyc();
        cyc();
        Green  = 4'b0000;
        Yellow = 4'b0001;
        cyc();
        checks++;
        if (depart !== 4'b0000 || queue_cnt[3:0] !== 4'd2) begin
            errors++; $display("FAIL yellow_no_depart got dep=%b cnt=%0d want dep=0000 cnt=2", depart, queue_cnt[3:0]);
        end
        cyc();
        Yellow = 4'b0000;
        Green  = 4'b0001;
        cyc();
        checks++;
        if (depart !== 4'b0000) begin
            errors++; $display("FAIL yellow_pace_reset_e1 got %b want 0000", depart);
        end
        cyc();
        checks++;
        if (depart !== 4'b0000) begin
            errors++; $display("FAIL yellow_pace_reset_e2 got %b want 0000", depart);
        end
        cyc();
        checks++;
        if (depart !== 4'b0001 || queue_cnt[3:0] !== 4'd1) begin
            errors++; $display("FAIL yellow_resume_drain got dep=%b cnt=%0d want dep=0001 cnt=1", depart, queue_cnt[3:0]);
        end
        all_red();
        cyc();
        checks++;
        if (conflict !== 1'b0) begin
            errors++; $display("FAIL no_false_conflict got %b want 0", conflict);
        end
    endtask

    task automatic test_conflict();
        Green = 4'b0101;
        Red   = 4'b1010;
        cyc();
        all_red();
        checks++;
        if (conflict !== 1'b1) begin
            errors++; $display("FAIL conflict_two_green got %b want 1", conflict);
        end
        repeat (3) cyc();
        checks++;
        if (conflict !== 1'b1) begin
            errors++; $display("FAIL conflict_sticky got %b want 1", conflict);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({Traffic, queue_cnt, depart, overflow, conflict} !== 29'd0) begin
            errors++; $display("FAIL async_reset got %h want 0", {Traffic, queue_cnt, depart, overflow, conflict});
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (conflict !== 1'b0) begin
            errors++; $display("FAIL conflict_cleared got %b want 0", conflict);
        end
        Green = 4'b0010;
        cyc();
        all_red();
        checks++;
        if (conflict !== 1'b1) begin
            errors++; $display("FAIL conflict_red_green got %b want 1", conflict);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        Red = 4'b1110;
        cyc();
        all_red();
        checks++;
        if (conflict !== 1'b1) begin
            errors++; $display("FAIL conflict_dark_lane got %b want 1", conflict);
        end
    endtask

    initial begin
        test_reset();
        test_arrivals();
        test_drain_pacing();
        test_back_to_back();
        test_yellow_interrupt();
        test_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
